// File: rtl/zx_keyboard_pkg.sv
// Shared types, special scan codes and the PS/2 set-2 to Spectrum matrix map.
// Optional feature macro: ZX_KBD_CURSOR_EN (E0-prefixed arrows -> CAPS SHIFT + 5/6/7/8).
package zx_kbd_pkg;

    typedef logic [2:0] row_t;
    typedef logic [2:0] col_t;

    localparam logic [7:0] SC_RELEASE = 8'hF0;
    localparam logic [7:0] SC_EXTEND  = 8'hE0;
    localparam logic [7:0] SC_F1      = 8'h05;
    localparam logic [7:0] SC_F11     = 8'h78;
    localparam logic [7:0] SC_F12     = 8'h07;
    localparam logic [7:0] SC_DEL     = 8'h71;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_ALT     = 8'h11;

    typedef struct packed {
        logic hit;
        logic dual;
        row_t rowA;
        col_t colA;
        row_t rowB;
        col_t colB;
    } key_map_t;

    typedef struct packed {
        logic lctrl;
        logic rctrl;
        logic lalt;
        logic ralt;
        logic del;
        logic bksp;
        logic f1;
        logic f11;
        logic f12;
    } held_t;

    // Positions are written in octal as {row, column}, e.g. 6'o34 = row 3, column 4.
    function automatic key_map_t mapScanCode(input logic [7:0] code, input logic ext);
        key_map_t m;
        logic [5:0] posA;
        logic [5:0] posB;
        m = '0;
        posA = '0;
        posB = '0;
        m.hit = 1'b1;
        if (ext) begin
`ifdef ZX_KBD_CURSOR_EN
            m.dual = 1'b1;
            case (code)
                8'h6B:   posB = 6'o34;
                8'h72:   posB = 6'o44;
                8'h75:   posB = 6'o43;
                8'h74:   posB = 6'o42;
                default: m.hit = 1'b0;
            endcase
`else
            m.hit = 1'b0;
`endif
        end else begin
            case (code)
                8'h12: posA = 6'o00;  8'h1A: posA = 6'o01;  8'h22: posA = 6'o02;
                8'h21: posA = 6'o03;  8'h2A: posA = 6'o04;
                8'h1C: posA = 6'o10;  8'h1B: posA = 6'o11;  8'h23: posA = 6'o12;
                8'h2B: posA = 6'o13;  8'h34: posA = 6'o14;
                8'h15: posA = 6'o20;  8'h1D: posA = 6'o21;  8'h24: posA = 6'o22;
                8'h2D: posA = 6'o23;  8'h2C: posA = 6'o24;
                8'h16: posA = 6'o30;  8'h1E: posA = 6'o31;  8'h26: posA = 6'o32;
                8'h25: posA = 6'o33;  8'h2E: posA = 6'o34;
                8'h45: posA = 6'o40;  8'h46: posA = 6'o41;  8'h3E: posA = 6'o42;
                8'h3D: posA = 6'o43;  8'h36: posA = 6'o44;
                8'h4D: posA = 6'o50;  8'h44: posA = 6'o51;  8'h43: posA = 6'o52;
                8'h3C: posA = 6'o53;  8'h35: posA = 6'o54;
                8'h5A: posA = 6'o60;  8'h4B: posA = 6'o61;  8'h42: posA = 6'o62;
                8'h3B: posA = 6'o63;  8'h33: posA = 6'o64;
                8'h29: posA = 6'o70;  8'h59: posA = 6'o71;  8'h3A: posA = 6'o72;
                8'h31: posA = 6'o73;  8'h32: posA = 6'o74;
                SC_BKSP: begin
                    posA   = 6'o00;
                    posB   = 6'o40;
                    m.dual = 1'b1;
                end
                default: m.hit = 1'b0;
            endcase
        end
        m.rowA = posA[5:3];
        m.colA = posA[2:0];
        m.rowB = posB[5:3];
        m.colB = posB[2:0];
        return m;
    endfunction

endpackage

// File: rtl/zx_keyboard_if.sv
// Keyboard-side bundle: PS/2 lines in, CPU row select in, column data and hotkey levels out.
interface zx_keyboard_if;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic [7:0] addr_hi;
    logic [4:0] key_data;
    logic       F1;
    logic       F11;
    logic       warm_reset;
    logic       cold_reset;
    logic       test_reset;

    modport master (
        output ps2_kbd_clk, ps2_kbd_data, addr_hi,
        input  key_data, F1, F11, warm_reset, cold_reset, test_reset
    );

    modport slave (
        input  ps2_kbd_clk, ps2_kbd_data, addr_hi,
        output key_data, F1, F11, warm_reset, cold_reset, test_reset
    );
endinterface

// File: rtl/zx_keyboard_ps2_rx.sv
// PS/2 receiver: synchronise, glitch-filter the clock, shift 11-bit frames, check and strobe bytes.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 28000
) (
    input  logic       clk_sys,
    input  logic       nRESET,
    input  logic       i_ps2Clk,
    input  logic       i_ps2Data,
    output logic [7:0] o_byte,
    output logic       o_valid
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_clkSync;
    logic [1:0]    r_dataSync;
    logic [FW-1:0] r_filtCnt;
    logic          r_filtClk;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitCnt;
    logic [TW-1:0] r_toCnt;
    logic [7:0]    r_byte;
    logic          r_valid;

    logic          w_flip;
    logic          w_fall;
    logic [10:0]   w_frame;
    logic          w_frameOk;

    assign w_flip    = (r_clkSync[1] != r_filtClk) && (r_filtCnt == FW'(FILTER_LEN - 1));
    assign w_fall    = w_flip && r_filtClk;
    assign w_frame   = {r_dataSync[1], r_shift};
    assign w_frameOk = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_clkSync  <= '0;
            r_dataSync <= '0;
            r_filtCnt  <= '0;
            r_filtClk  <= 1'b0;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_ps2Clk};
            r_dataSync <= {r_dataSync[0], i_ps2Data};
            if (r_clkSync[1] == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (w_flip) begin
                r_filtClk <= ~r_filtClk;
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + 1'b1;
            end
        end
    end

    // Bits arrive LSB first into the top of r_shift; the stop bit is checked straight off the pin.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_toCnt  <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_fall) begin
                r_toCnt <= '0;
                if (r_bitCnt == 4'd10) begin
                    r_bitCnt <= '0;
                    if (w_frameOk) begin
                        r_byte  <= w_frame[8:1];
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_shift  <= w_frame[10:1];
                    r_bitCnt <= r_bitCnt + 4'd1;
                end
            end else if (r_bitCnt != 4'd0) begin
                if (r_toCnt == TW'(TIMEOUT - 1)) begin
                    r_bitCnt <= '0;
                    r_toCnt  <= '0;
                end else begin
                    r_toCnt <= r_toCnt + 1'b1;
                end
            end else begin
                r_toCnt <= '0;
            end
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;
endmodule

// File: rtl/zx_keyboard.sv
// PS/2 to ZX Spectrum keyboard matrix with hotkey and reset-combo outputs.
// Build option: define ZX_KBD_CURSOR_EN to map E0-prefixed arrows onto CAPS SHIFT + 5/6/7/8.
module zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 28000
) (
    input  logic         clk_sys,
    input  logic         nRESET,
    zx_keyboard_if.slave bus
);
    logic [7:0]      w_rxByte;
    logic            w_rxValid;
    key_map_t        w_map;
    logic            w_isKey;
    logic            w_press;
    held_t           w_heldNext;
    logic            w_ctrl;
    logic            w_alt;
    logic [4:0]      w_colOr;

    logic            r_release;
    logic            r_extend;
    logic [7:0][4:0] r_matrix;
    held_t           r_held;
    logic            r_f1;
    logic            r_f11;
    logic            r_warm;
    logic            r_cold;
    logic            r_test;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .i_ps2Clk  (bus.ps2_kbd_clk),
        .i_ps2Data (bus.ps2_kbd_data),
        .o_byte    (w_rxByte),
        .o_valid   (w_rxValid)
    );

    assign w_map   = mapScanCode(w_rxByte, r_extend);
    assign w_isKey = w_rxValid && (w_rxByte != SC_RELEASE) && (w_rxByte != SC_EXTEND);
    assign w_press = ~r_release;

    always_comb begin
        w_heldNext = r_held;
        if (w_isKey) begin
            case (w_rxByte)
                SC_CTRL: if (r_extend) w_heldNext.rctrl = w_press; else w_heldNext.lctrl = w_press;
                SC_ALT:  if (r_extend) w_heldNext.ralt  = w_press; else w_heldNext.lalt  = w_press;
                SC_DEL:  w_heldNext.del  = w_press;
                SC_BKSP: w_heldNext.bksp = w_press;
                SC_F1:   w_heldNext.f1   = w_press;
                SC_F11:  w_heldNext.f11  = w_press;
                SC_F12:  w_heldNext.f12  = w_press;
                default: ;
            endcase
        end
    end

    assign w_ctrl = w_heldNext.lctrl | w_heldNext.rctrl;
    assign w_alt  = w_heldNext.lalt  | w_heldNext.ralt;

    // Outputs are taken from the next-state flags so they move on the same edge as the flags.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_release <= 1'b0;
            r_extend  <= 1'b0;
            r_matrix  <= '0;
            r_held    <= '0;
            r_f1      <= 1'b0;
            r_f11     <= 1'b0;
            r_warm    <= 1'b0;
            r_cold    <= 1'b0;
            r_test    <= 1'b0;
        end else begin
            r_held <= w_heldNext;
            r_f1   <= w_heldNext.f1;
            r_f11  <= w_heldNext.f11;
            r_warm <= w_ctrl & w_alt & w_heldNext.del;
            r_cold <= w_ctrl & w_alt & w_heldNext.bksp;
            r_test <= w_ctrl & w_alt & w_heldNext.f12;
            if (w_rxValid) begin
                if (w_rxByte == SC_RELEASE) begin
                    r_release <= 1'b1;
                end else if (w_rxByte == SC_EXTEND) begin
                    r_extend <= 1'b1;
                end else begin
                    r_release <= 1'b0;
                    r_extend  <= 1'b0;
                    if (w_map.hit) begin
                        r_matrix[w_map.rowA][w_map.colA] <= w_press;
                        if (w_map.dual)
                            r_matrix[w_map.rowB][w_map.colB] <= w_press;
                    end
                end
            end
        end
    end

    always_comb begin
        w_colOr = '0;
        for (int r = 0; r < 8; r++)
            if (!bus.addr_hi[r]) w_colOr = w_colOr | r_matrix[r];
    end

    assign bus.key_data   = ~w_colOr;
    assign bus.F1         = r_f1;
    assign bus.F11        = r_f11;
    assign bus.warm_reset = r_warm;
    assign bus.cold_reset = r_cold;
    assign bus.test_reset = r_test;
endmodule

// File: tb/tb_zx_keyboard.sv
// Directed bench for zx_keyboard: PS/2 frames in, matrix rows and hotkey levels checked.
// Expectations follow ZX_KBD_CURSOR_EN when the bench is built with it.
module tb_zx_keyboard;
    logic clk_sys = 1'b0;
    logic nRESET  = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    zx_keyboard_if bus();

    zx_keyboard dut (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic probeRow(input string tag, input logic [7:0] addr, input logic [4:0] exp);
        bus.addr_hi = addr;
        #1;
        checkOutput(tag, {3'b000, bus.key_data}, {3'b000, exp});
    endtask

    // Sends the first nBits bits of a frame; badParity flips the parity bit to even.
    task automatic applyStimulus(input logic [7:0] code, input logic badParity, input int nBits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            bus.ps2_kbd_data = frame[i];
            repeat (10) @(negedge clk_sys);
            bus.ps2_kbd_clk = 1'b0;
            repeat (20) @(negedge clk_sys);
            bus.ps2_kbd_clk = 1'b1;
            repeat (10) @(negedge clk_sys);
        end
        bus.ps2_kbd_data = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    task automatic sendKey(input logic [7:0] code);
        applyStimulus(code, 1'b0, 11);
    endtask

    initial begin
        bus.ps2_kbd_clk  = 1'b1;
        bus.ps2_kbd_data = 1'b1;
        bus.addr_hi      = 8'h00;
        repeat (5) @(negedge clk_sys);
        probeRow("rst keys", 8'h00, 5'b11111);
        checkOutput("rst F1",   {7'b0, bus.F1},         8'h00);
        checkOutput("rst F11",  {7'b0, bus.F11},        8'h00);
        checkOutput("rst warm", {7'b0, bus.warm_reset}, 8'h00);
        checkOutput("rst cold", {7'b0, bus.cold_reset}, 8'h00);
        checkOutput("rst test", {7'b0, bus.test_reset}, 8'h00);
        nRESET = 1'b1;
        repeat (30) @(negedge clk_sys);

        sendKey(8'h1C);
        probeRow("A row FD", 8'hFD, 5'b11110);
        probeRow("A row FE", 8'hFE, 5'b11111);
        probeRow("A row FF", 8'hFF, 5'b11111);
        probeRow("A row 00", 8'h00, 5'b11110);
        sendKey(8'hF0);
        sendKey(8'h1C);
        probeRow("A break", 8'hFD, 5'b11111);

        applyStimulus(8'h1C, 1'b1, 11);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] sel;
            sel = ~(8'h01 << r);
            probeRow($sformatf("badpar row %0d", r), sel, 5'b11111);
        end

        applyStimulus(8'h1C, 1'b0, 5);
        repeat (28010) @(negedge clk_sys);
        sendKey(8'h1C);
        probeRow("timeout A FD", 8'hFD, 5'b11110);
        probeRow("timeout A FE", 8'hFE, 5'b11111);
        sendKey(8'hF0);
        sendKey(8'h1B);
        probeRow("stray break", 8'hFD, 5'b11110);
        sendKey(8'hF0);
        sendKey(8'h1C);
        probeRow("A break 2", 8'hFD, 5'b11111);

        sendKey(8'h66);
        probeRow("bksp caps", 8'hFE, 5'b11110);
        probeRow("bksp zero", 8'hEF, 5'b11110);
        sendKey(8'hF0);
        sendKey(8'h66);
        probeRow("bksp rel caps", 8'hFE, 5'b11111);
        probeRow("bksp rel zero", 8'hEF, 5'b11111);

        sendKey(8'hE0);
        sendKey(8'h6B);
`ifdef ZX_KBD_CURSOR_EN
        probeRow("left caps", 8'hFE, 5'b11110);
        probeRow("left five", 8'hF7, 5'b01111);
`else
        probeRow("left caps", 8'hFE, 5'b11111);
        probeRow("left five", 8'hF7, 5'b11111);
`endif
        sendKey(8'hE0);
        sendKey(8'hF0);
        sendKey(8'h6B);
        probeRow("left rel caps", 8'hFE, 5'b11111);
        probeRow("left rel five", 8'hF7, 5'b11111);

        sendKey(8'h14);
        sendKey(8'h11);
        checkOutput("warm early", {7'b0, bus.warm_reset}, 8'h00);
        sendKey(8'hE0);
        sendKey(8'h71);
        checkOutput("warm set", {7'b0, bus.warm_reset}, 8'h01);
        checkOutput("cold idle", {7'b0, bus.cold_reset}, 8'h00);
        probeRow("mods no matrix", 8'h00, 5'b11111);
        sendKey(8'hF0);
        sendKey(8'h14);
        checkOutput("warm clear", {7'b0, bus.warm_reset}, 8'h00);
        sendKey(8'hE0);
        sendKey(8'hF0);
        sendKey(8'h71);
        sendKey(8'hE0);
        sendKey(8'h14);
        sendKey(8'h66);
        checkOutput("cold set", {7'b0, bus.cold_reset}, 8'h01);
        checkOutput("warm idle", {7'b0, bus.warm_reset}, 8'h00);
        sendKey(8'hF0);
        sendKey(8'h66);
        checkOutput("cold clear", {7'b0, bus.cold_reset}, 8'h00);
        sendKey(8'h07);
        checkOutput("test set", {7'b0, bus.test_reset}, 8'h01);
        sendKey(8'hF0);
        sendKey(8'h07);
        checkOutput("test clear", {7'b0, bus.test_reset}, 8'h00);
        sendKey(8'hE0);
        sendKey(8'hF0);
        sendKey(8'h14);
        sendKey(8'hF0);
        sendKey(8'h11);

        sendKey(8'h1C);
        sendKey(8'h05);
        sendKey(8'h78);
        checkOutput("F1 set",  {7'b0, bus.F1},  8'h01);
        checkOutput("F11 set", {7'b0, bus.F11}, 8'h01);
        probeRow("F keys no matrix", 8'h00, 5'b11110);
        applyStimulus(8'h32, 1'b0, 4);
        #3;
        nRESET = 1'b0;
        probeRow("async rst keys", 8'hFD, 5'b11111);
        checkOutput("async rst F1",  {7'b0, bus.F1},  8'h00);
        checkOutput("async rst F11", {7'b0, bus.F11}, 8'h00);
        repeat (5) @(negedge clk_sys);
        nRESET = 1'b1;
        repeat (30) @(negedge clk_sys);
        sendKey(8'h1C);
        probeRow("post rst A", 8'hFD, 5'b11110);
        checkOutput("post rst F1", {7'b0, bus.F1}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zx_keyboard.md
ZX_KEYBOARD -- requirements
Module: zx_keyboard

Interface
REQ-001 FILTER_LEN, 8, number of consecutive equal synchronised samples needed to accept a new ps2_kbd_clk level.
REQ-002 TIMEOUT, 28000, number of clk_sys cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-003 clk_sys  in  1  system clock, 28 MHz.
REQ-004 nRESET  in  1  asynchronous, active-low reset.
REQ-005 ps2_kbd_clk  in  1  PS/2 keyboard clock, asynchronous to clk_sys.
REQ-006 ps2_kbd_data  in  1  PS/2 keyboard data, asynchronous to clk_sys.
REQ-007 addr_hi  in  8  CPU A15..A8; a low bit selects the corresponding matrix row.
REQ-008 key_data  out  5  active-low column data for ULA port FE bits 4..0.
REQ-009 F1  out  1  high while F1 (scan code 05) is held.
REQ-010 F11  out  1  high while F11 (scan code 78) is held.
REQ-011 warm_reset  out  1  high while Ctrl+Alt+Del are all held.
REQ-012 cold_reset  out  1  high while Ctrl+Alt+Backspace are all held.
REQ-013 test_reset  out  1  high while Ctrl+Alt+F12 are all held.

Function
REQ-014 ps2_kbd_clk and ps2_kbd_data SHALL each pass through a 2-flop synchroniser; the filtered clock SHALL change level only after FILTER_LEN identical synchronised samples.
REQ-015 Data SHALL be sampled on each falling edge of the filtered clock, forming an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-016 The receiver SHALL accept a byte only if start=0, stop=1 and parity is odd; otherwise the frame SHALL be discarded silently with no state change.
REQ-017 A byte-valid strobe SHALL be asserted for exactly one clk_sys cycle, at most 2 cycles after the stop-bit edge.
REQ-018 If TIMEOUT cycles elapse with no falling edge while the bit counter is non-zero, the bit counter SHALL return to 0 and the partial frame SHALL be dropped.
REQ-019 The decoder state SHALL consist of a release flag and an extended flag: byte F0 sets release, byte E0 sets extended, and any other byte is applied as a key code and then clears both flags.
REQ-020 Key state SHALL be a 40-bit matrix (8 rows x 5 columns, 1 = pressed); a make code sets the mapped bit(s) and a break code clears them.
REQ-021 Unmapped codes SHALL only clear the flags.
REQ-022 A key mapping to two matrix positions (e.g. Backspace = CAPS SHIFT + 0) SHALL set and clear both positions together.
REQ-023 key_data[i] SHALL be combinational: the inverse of the OR of matrix[r][i] over all rows r with addr_hi[r]=0; it SHALL be 5'b11111 when addr_hi=8'hFF.
REQ-024 Left and right Ctrl and Alt (E0-prefixed variants included) SHALL be tracked in separate modifier flags that do not affect the matrix.
REQ-025 F1, F11 and the three reset outputs SHALL be registered levels derived from held-key flags, with 1 cycle of latency after the byte strobe.
REQ-026 A break code for a key that is not pressed SHALL have no effect.
REQ-027 A new frame SHALL NOT be blocked by decode in progress: decode completes in 1 cycle.

Reset
REQ-028 While nRESET=0: synchronisers, filter, bit counter, timeout counter, flags, matrix and modifiers SHALL be 0; key_data SHALL be 5'b11111; F1, F11, warm_reset, cold_reset and test_reset SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; reception SHALL resume at the next start bit after release.

Configuration
REQ-030 With ZX_KBD_CURSOR_EN defined, E0-prefixed arrow codes SHALL map to CAPS SHIFT plus one digit key: 6B to 5, 72 to 6, 75 to 7, 74 to 8.
REQ-031 Without ZX_KBD_CURSOR_EN, arrow codes SHALL be treated as unmapped.

Structure
REQ-032 Package zx_kbd_pkg SHALL hold the row/column index typedefs, the special scan-code constants (F0, E0, 05, 78, 07, 71, 66, 14, 11) and the scan-code-to-matrix mapping function.
REQ-033 Sub-module ps2_rx SHALL contain the synchroniser, filter, frame shift register, parity check and timeout, and SHALL output a byte plus a valid strobe.

Verification
REQ-034 Frame 1C, then addr_hi=FD -> key_data=11110; then F0,1C -> key_data=11111.
REQ-035 Frame 1C with even parity -> matrix unchanged; key_data stays 11111 for every addr_hi.
REQ-036 Send 5 bits, idle TIMEOUT+10 cycles, then valid 1C -> only 1C decoded; row FD column 0 pressed.
REQ-037 With cursor enabled, send E0,6B -> addr_hi=FE gives 11110 and addr_hi=F7 gives 01111; send E0,F0,6B -> both rows read 11111.
REQ-038 Send 14, 11, E0,71 -> warm_reset=1 one cycle after the strobe; send F0,14 -> warm_reset=0.
REQ-039 Press 1C, then pulse nRESET low asynchronously mid-frame -> key_data=11111 immediately, F1=F11=0; the next valid frame decodes correctly.
